// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-to-memory initiator: FSM encoding,
// default bus widths and the read-latency counter width.
package cpu_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned CNT_W          = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_master_if.sv
// Request/response channels plus the single-port memory bus, seen from
// the initiator (master) and from the CPU/memory side (slave).
interface mem_master_if
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  busy;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_din, busy
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, mem_we, mem_addr, mem_din, busy
    );
endinterface

// File: rtl/mem_master.sv
// Single-outstanding load/store initiator for the single-port memory:
// stores take two cycles, loads wait RD_LATENCY edges before capture.
module mem_master
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_master_if.master  bus
);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LATENCY);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr;
                        if (bus.req_write) begin
                            din_q <= bus.req_wdata;
                            we_q  <= 1'b1;
                            state <= WRITE;
                        end else begin
                            we_q  <= 1'b0;
                            cnt   <= LAT_INIT;
                            state <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                end
                READ_WAIT: begin
                    // Counter reaching zero marks the edge where mem_dout is valid.
                    if (cnt == '0) begin
                        rsp_rdata_q <= bus.mem_dout;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: a registered-read build (u1) and an
// asynchronous-read build (u0), each with its own memory model.
module tb_mem_master;
    import cpu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   we1_cnt = 0;
    int   rsp1_cnt = 0;
    int   rsp_base;

    always #5 clk = ~clk;

    mem_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b1 ();
    mem_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) b0 ();

    mem_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    mem_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );

    // Memories hold off writes while the system is in reset.
    logic [7:0] mem1 [256];
    logic [7:0] mem0 [256];
    logic [7:0] dout1;

    always @(posedge clk) begin
        if (rst_n && b1.mem_we) mem1[b1.mem_addr] <= b1.mem_din;
        dout1 <= mem1[b1.mem_addr];
        if (rst_n && b0.mem_we) mem0[b0.mem_addr] <= b0.mem_din;
    end
    assign b1.mem_dout = dout1;
    assign b0.mem_dout = mem0[b0.mem_addr];

    always @(posedge clk) begin
        if (b1.mem_we) we1_cnt++;
        if (b1.rsp_valid && b1.rsp_ready) rsp1_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Store on b1; req_valid is left high so back-to-back stores stream.
    task automatic store1(input logic [7:0] a, input logic [7:0] d);
        b1.req_valid = 1'b1;
        b1.req_write = 1'b1;
        b1.req_addr  = a;
        b1.req_wdata = d;
        tick();
        chk("st_we_high", b1.mem_we, 1'b1);
        chk("st_addr", b1.mem_addr, a);
        chk("st_din", b1.mem_din, d);
        chk("st_rdy_low", b1.req_ready, 1'b0);
        tick();
        chk("st_we_low", b1.mem_we, 1'b0);
        chk("st_rdy_back", b1.req_ready, 1'b1);
    endtask

    task automatic load1(input logic [7:0] a, input logic [7:0] exp);
        b1.req_valid = 1'b1;
        b1.req_write = 1'b0;
        b1.req_addr  = a;
        b1.rsp_ready = 1'b1;
        tick();
        b1.req_valid = 1'b0;
        chk("ld_busy", b1.busy, 1'b1);
        chk("ld_v_e1", b1.rsp_valid, 1'b0);
        tick();
        chk("ld_v_e2pre", b1.rsp_valid, 1'b0);
        tick();
        chk("ld_v_e2", b1.rsp_valid, 1'b1);
        chk("ld_data", b1.rsp_rdata, exp);
        tick();
        chk("ld_v_done", b1.rsp_valid, 1'b0);
        chk("ld_rdy", b1.req_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        b1.req_valid = 1'b1; b1.req_write = 1'b1;
        b1.req_addr = 8'h33; b1.req_wdata = 8'h99; b1.rsp_ready = 1'b0;
        b0.req_valid = 1'b0; b0.req_write = 1'b0;
        b0.req_addr = 8'h00; b0.req_wdata = 8'h00; b0.rsp_ready = 1'b1;

        tick();
        tick();
        chk("rst_req_ready", b1.req_ready, 1'b1);
        chk("rst_rsp_valid", b1.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", b1.rsp_rdata, 8'h00);
        chk("rst_mem_we", b1.mem_we, 1'b0);
        chk("rst_mem_addr", b1.mem_addr, 8'h00);
        chk("rst_mem_din", b1.mem_din, 8'h00);
        chk("rst_busy", b1.busy, 1'b0);
        chk("rst_no_we", we1_cnt, 0);

        rst_n = 1'b1;
        store1(8'h00, 8'hA5);
        store1(8'h01, 8'h5A);
        store1(8'h02, 8'hFF);
        b1.req_valid = 1'b0;
        chk("we_pulses", we1_cnt, 3);
        chk("mem0", mem1[0], 8'hA5);
        chk("mem1", mem1[1], 8'h5A);
        chk("mem2", mem1[2], 8'hFF);

        load1(8'h00, 8'hA5);
        load1(8'h01, 8'h5A);
        load1(8'h02, 8'hFF);
        chk("rsp_count", rsp1_cnt, 3);

        store1(8'hFF, 8'hC3);
        b1.req_valid = 1'b0;
        load1(8'hFF, 8'hC3);

        // Back-pressured load: response must hold for 5 cycles.
        rsp_base = rsp1_cnt;
        b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 8'h01;
        b1.rsp_ready = 1'b0;
        tick();
        b1.req_valid = 1'b0;
        tick();
        tick();
        chk("bp_rise", b1.rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", b1.rsp_valid, 1'b1);
            chk("bp_data", b1.rsp_rdata, 8'h5A);
            chk("bp_rdy", b1.req_ready, 1'b0);
        end
        b1.rsp_ready = 1'b1;
        tick();
        chk("bp_drop", b1.rsp_valid, 1'b0);
        chk("bp_one_xfer", rsp1_cnt - rsp_base, 1);

        // Reset during the WRITE cycle drops the store.
        store1(8'h10, 8'h11);
        b1.req_wdata = 8'h3C;
        tick();
        chk("rw_we", b1.mem_we, 1'b1);
        rst_n = 1'b0;
        b1.req_valid = 1'b0;
        tick();
        chk("rw_we_clr", b1.mem_we, 1'b0);
        chk("rw_idle", b1.busy, 1'b0);
        chk("rw_rdy", b1.req_ready, 1'b1);
        chk("rw_rdata", b1.rsp_rdata, 8'h00);
        rst_n = 1'b1;
        load1(8'h10, 8'h11);

        // Asynchronous-read build.
        b0.req_valid = 1'b1; b0.req_write = 1'b1;
        b0.req_addr = 8'h7F; b0.req_wdata = 8'hFF;
        tick();
        chk("l0_we", b0.mem_we, 1'b1);
        b0.req_write = 1'b0;
        tick();
        chk("l0_mem", mem0[8'h7F], 8'hFF);
        tick();
        b0.req_valid = 1'b0;
        chk("l0_v_acc", b0.rsp_valid, 1'b0);
        tick();
        chk("l0_v_e1", b0.rsp_valid, 1'b1);
        chk("l0_data", b0.rsp_rdata, 8'hFF);
        tick();
        chk("l0_done", b0.rsp_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
